// File: rtl/cpc_clk_pkg.sv
// Shared constants and the effective-ratio rule for the clock-enable generator.
package cpc_clk_pkg;

  localparam int unsigned CEN_DEF_CH    = 4;
  localparam int unsigned CEN_DEF_CNT_W = 8;
  localparam int unsigned CEN_DEF_RATIO = 3;

  // Master terminal count: a ratio of 0 is promoted to 1; FAST halves the divide, never below /2.
  function automatic logic [31:0] eff_ratio(input logic [31:0] ratio, input logic fast);
    logic [31:0] r;
    logic [31:0] h;
    r = (ratio == 32'd0) ? 32'd1 : ratio;
    h = ((r + 32'd1) >> 1) - 32'd1;
    if (fast) r = (h < 32'd1) ? 32'd1 : h;
    return r;
  endfunction

endpackage

// File: rtl/cpc_cen_chan.sv
// One derived channel: counts master ticks and toggles its square wave every div+1 ticks.
module cpc_cen_chan
  import cpc_clk_pkg::*;
#(
  parameter int unsigned CNT_W = CEN_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             ch_clk,
  output logic             cen_p,
  output logic             cen_n
);

  logic [CNT_W-1:0] ccnt;
  logic [CNT_W-1:0] div_q;

  // Divider is latched only when the count restarts, so a lowered div never overruns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ccnt   <= '0;
      div_q  <= div;
      ch_clk <= 1'b0;
      cen_p  <= 1'b0;
      cen_n  <= 1'b0;
    end else begin
      cen_p <= 1'b0;
      cen_n <= 1'b0;
      if (clr) begin
        ccnt   <= '0;
        div_q  <= div;
        ch_clk <= 1'b0;
      end else if (tick) begin
        if (ccnt == div_q) begin
          ccnt   <= '0;
          div_q  <= div;
          ch_clk <= ~ch_clk;
          cen_p  <= ~ch_clk;
          cen_n  <= ch_clk;
        end else begin
          ccnt <= ccnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cpc_cen_gen.sv
// Master clock-enable divider with CH derived channels; FAST halving is built only
// when CPC_CEN_FAST_EN is defined.
module cpc_cen_gen
  import cpc_clk_pkg::*;
#(
  parameter int unsigned CH        = CEN_DEF_CH,
  parameter int unsigned CNT_W     = CEN_DEF_CNT_W,
  parameter int unsigned DEF_RATIO = CEN_DEF_RATIO
) (
  input  logic                clk,
  input  logic                RESET_N,
  input  logic [CNT_W-1:0]    RATIO,
  input  logic                RATIO_LD,
  output logic                RATIO_ACK,
  input  logic                PAUSE,
  input  logic                SYNC,
  input  logic [CH*CNT_W-1:0] CH_DIV,
  output logic                CEN_BASE,
  output logic                CLK_BASE,
  output logic [CH-1:0]       CH_CLK,
  output logic [CH-1:0]       CEN_P,
  output logic [CH-1:0]       CEN_N
`ifdef CPC_CEN_FAST_EN
  ,
  input  logic                FAST
`endif
);

  logic [CNT_W-1:0] mcnt;
  logic [CNT_W-1:0] r_cur;
  logic [CNT_W-1:0] r_term;
  logic [CNT_W-1:0] half;
  logic             fast_q;
  logic             fast_in;
  logic             sync_q;
  logic             tick_c;
  logic             wrap_c;
  logic             sync_c;

`ifdef CPC_CEN_FAST_EN
  assign fast_in = FAST;
`else
  assign fast_in = 1'b0;
`endif

  // Terminal count, duty threshold and the tick/wrap/realign strobes; PAUSE masks all of them.
  always_comb begin
    r_term = CNT_W'(eff_ratio(32'(r_cur), fast_q));
    half   = CNT_W'((32'(r_term) + 32'd1) >> 1);
    tick_c = !PAUSE && (mcnt == '0);
    wrap_c = !PAUSE && (mcnt == r_term);
    sync_c = wrap_c && (sync_q || SYNC);
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      mcnt      <= '0;
      r_cur     <= CNT_W'(DEF_RATIO);
      fast_q    <= 1'b0;
      sync_q    <= 1'b0;
      CEN_BASE  <= 1'b0;
      CLK_BASE  <= 1'b0;
      RATIO_ACK <= 1'b0;
    end else if (PAUSE) begin
      CEN_BASE  <= 1'b0;
      RATIO_ACK <= 1'b0;
      sync_q    <= sync_q | SYNC;
    end else begin
      CEN_BASE  <= tick_c;
      CLK_BASE  <= (mcnt >= half);
      RATIO_ACK <= wrap_c && RATIO_LD;
      if (wrap_c) begin
        mcnt   <= '0;
        fast_q <= fast_in;
        sync_q <= 1'b0;
        if (RATIO_LD) r_cur <= (RATIO == '0) ? CNT_W'(1) : RATIO;
      end else begin
        mcnt   <= mcnt + CNT_W'(1);
        sync_q <= sync_q | SYNC;
      end
    end
  end

  for (genvar i = 0; i < int'(CH); i++) begin : g_chan
    cpc_cen_chan #(.CNT_W(CNT_W)) u_chan (
      .clk    (clk),
      .rst_n  (RESET_N),
      .tick   (tick_c),
      .clr    (sync_c),
      .div    (CH_DIV[i*CNT_W +: CNT_W]),
      .ch_clk (CH_CLK[i]),
      .cen_p  (CEN_P[i]),
      .cen_n  (CEN_N[i])
    );
  end

endmodule

// File: tb/tb_cpc_cen_gen.sv
// Bench for cpc_cen_gen: directed scenarios plus random traffic against a period-level model.
module tb_cpc_cen_gen;
  localparam int unsigned CH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEF_RATIO = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ratio_ld = 1'b0;
  logic pause = 1'b0;
  logic sync = 1'b0;
  logic [CNT_W-1:0] ratio = '0;
  logic [CH*CNT_W-1:0] ch_div;
  logic ratio_ack, cen_base, clk_base;
  logic [CH-1:0] ch_clk, cen_p, cen_n;
`ifdef CPC_CEN_FAST_EN
  logic fast = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // Model: position inside the current period, period length in clks, per-channel tick counts.
  int m_pos, m_base, m_tk[CH], m_dv[CH];
  bit m_fast, m_sync;
  logic e_cen, e_clkb, e_ack;
  logic [CH-1:0] e_clk, e_p, e_n;

  always #5 clk = ~clk;

  cpc_cen_gen #(.CH(CH), .CNT_W(CNT_W), .DEF_RATIO(DEF_RATIO)) dut (
    .clk(clk), .RESET_N(reset_n), .RATIO(ratio), .RATIO_LD(ratio_ld), .RATIO_ACK(ratio_ack),
    .PAUSE(pause), .SYNC(sync), .CH_DIV(ch_div), .CEN_BASE(cen_base), .CLK_BASE(clk_base),
    .CH_CLK(ch_clk), .CEN_P(cen_p), .CEN_N(cen_n)
`ifdef CPC_CEN_FAST_EN
    , .FAST(fast)
`endif
  );

  function automatic int div_of(int i);
    return int'(ch_div[i*CNT_W +: CNT_W]);
  endfunction

  function automatic int period_now();
    int h;
    h = m_base / 2;
    if (m_fast) return (h < 2) ? 2 : h;
    return m_base;
  endfunction

  task automatic model_step();
    int per;
    bit f;
`ifdef CPC_CEN_FAST_EN
    f = fast;
`else
    f = 1'b0;
`endif
    if (!reset_n) begin
      m_pos = 0; m_base = (DEF_RATIO == 0) ? 2 : int'(DEF_RATIO) + 1;
      m_fast = 1'b0; m_sync = 1'b0;
      e_cen = 1'b0; e_clkb = 1'b0; e_ack = 1'b0; e_clk = '0; e_p = '0; e_n = '0;
      for (int i = 0; i < CH; i++) begin m_tk[i] = 0; m_dv[i] = div_of(i); end
    end else if (pause) begin
      e_cen = 1'b0; e_ack = 1'b0; e_p = '0; e_n = '0;
      m_sync = m_sync | sync;
    end else begin
      per = period_now();
      e_cen = (m_pos == 0);
      e_clkb = (m_pos >= per / 2);
      e_ack = 1'b0; e_p = '0; e_n = '0;
      if (m_pos == 0)
        for (int i = 0; i < CH; i++) begin
          if (m_tk[i] == m_dv[i]) begin
            m_tk[i] = 0; m_dv[i] = div_of(i);
            e_clk[i] = ~e_clk[i];
            if (e_clk[i]) e_p[i] = 1'b1; else e_n[i] = 1'b1;
          end else m_tk[i]++;
        end
      m_sync = m_sync | sync;
      if (m_pos == per - 1) begin
        m_pos = 0; m_fast = f;
        if (ratio_ld) begin
          m_base = (ratio == '0) ? 2 : int'(ratio) + 1;
          e_ack = 1'b1;
        end
        if (m_sync) begin
          e_clk = '0; m_sync = 1'b0;
          for (int i = 0; i < CH; i++) begin m_tk[i] = 0; m_dv[i] = div_of(i); end
        end
      end else m_pos++;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("cen_base", 32'(cen_base), 32'(e_cen));
    chk("clk_base", 32'(clk_base), 32'(e_clkb));
    chk("ratio_ack", 32'(ratio_ack), 32'(e_ack));
    chk("ch_clk", 32'(ch_clk), 32'(e_clk));
    chk("cen_p", 32'(cen_p), 32'(e_p));
    chk("cen_n", 32'(cen_n), 32'(e_n));
    chk("p_n_excl", 32'(cen_p & cen_n), 32'd0);
    chk("en_gated", 32'((cen_p | cen_n) & ~{CH{cen_base}}), 32'd0);
  endtask

  // Hold RATIO_LD until the model reports adoption (bounded).
  task automatic load_ratio(input logic [CNT_W-1:0] r, input bit with_sync);
    int n;
    ratio = r; ratio_ld = 1'b1; sync = with_sync;
    step();
    sync = 1'b0;
    n = 0;
    while (!e_ack && n < 64) begin step(); n++; end
    chk("ack_seen", 32'(e_ack), 32'd1);
    ratio_ld = 1'b0;
  endtask

  // Clks between two successive CEN_BASE pulses; a timeout reports 0.
  task automatic measure(output int len);
    int n;
    n = 0;
    while (!cen_base && n < 64) begin step(); n++; end
    len = 0;
    if (cen_base) begin
      step(); len = 1;
      while (!cen_base && len < 64) begin step(); len++; end
      if (!cen_base) len = 0;
    end
  endtask

  initial begin
    int len;
    ch_div = {8'd3, 8'd1, 8'd2, 8'd0};
    for (int k = 0; k < 3; k++) step();
    chk("reset_outs", 32'({cen_base, clk_base, ratio_ack, ch_clk, cen_p, cen_n}), 32'd0);

    // Reset release at the default /4 ratio.
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("rel_cen_base", 32'(cen_base), 32'((k % 4) == 1));
      chk("rel_cen_p0", 32'(cen_p[0]), 32'((k % 8) == 1));
      chk("rel_cen_n0", 32'(cen_n[0]), 32'((k % 8) == 5));
    end

    // Switch to /8 mid-period, then check the period.
    step();
    load_ratio(8'd7, 1'b0);
    measure(len);
    chk("ratio7_period", 32'(len), 32'd8);
    for (int k = 0; k < 40; k++) step();

    // Pause 10 clks mid-period stretches the interval by exactly 10.
    len = 0;
    while (!cen_base && len < 64) begin step(); len++; end
    len = 0;
    for (int k = 0; k < 3; k++) begin step(); len++; end
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin step(); len++; chk("pause_no_en", 32'({cen_base, cen_p, cen_n}), 32'd0); end
    pause = 1'b0;
    step(); len++;
    while (!cen_base && len < 64) begin step(); len++; end
    chk("pause_interval", 32'(len), 32'd18);

    // SYNC with a ratio request: both apply at the same wrap.
    for (int k = 0; k < 5; k++) step();
    load_ratio(8'd3, 1'b1);
    chk("sync_chclk_clr", 32'(ch_clk), 32'd0);
    chk("sync_no_cen_n", 32'(cen_n), 32'd0);
    step();
    chk("sync_next_p0", 32'(cen_p[0]), 32'd1);
    for (int k = 0; k < 30; k++) step();

    // Random traffic including mid-period resets and CH_DIV changes.
    for (int c = 0; c < 1500; c++) begin
      reset_n = ($urandom_range(0, 149) != 0);
      pause = ($urandom_range(0, 7) == 0);
      sync = ($urandom_range(0, 24) == 0);
      ratio_ld = ($urandom_range(0, 3) == 0);
      ratio = CNT_W'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0)
        ch_div[$urandom_range(0, CH - 1) * CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
`ifdef CPC_CEN_FAST_EN
      fast = ($urandom_range(0, 3) == 0);
`endif
      step();
    end
    reset_n = 1'b1; pause = 1'b0; sync = 1'b0; ratio_ld = 1'b0;
    for (int k = 0; k < 4; k++) step();

`ifdef CPC_CEN_FAST_EN
    fast = 1'b1;
    load_ratio(8'd3, 1'b0);
    measure(len);
    chk("fast_r3_period", 32'(len), 32'd2);
    load_ratio(8'd0, 1'b0);
    measure(len);
    chk("fast_r0_period", 32'(len), 32'd2);
    fast = 1'b0;
    for (int k = 0; k < 8; k++) step();
`endif

    // RATIO=0 is promoted to /2.
    load_ratio(8'd0, 1'b0);
    measure(len);
    chk("ratio0_period", 32'(len), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpc_cen_gen.md
CPC_CEN_GEN -- requirements
Module: cpc_cen_gen

Interface
REQ-001 SHALL have parameter CH, default 4: number of derived clock-enable channels.
REQ-002 SHALL have parameter CNT_W, default 8: width of the ratio and divider fields.
REQ-003 SHALL have parameter DEF_RATIO, default 3: master divide-minus-one loaded at reset, giving /4 (64->16 MHz).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 SHALL have port RESET_N, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port RATIO, input, CNT_W bits: requested master divide-minus-one.
REQ-007 SHALL have port RATIO_LD, input, 1 bit: level request to adopt RATIO.
REQ-008 SHALL have port RATIO_ACK, output, 1 bit: one-clk pulse when RATIO is adopted.
REQ-009 SHALL have port PAUSE, input, 1 bit: freezes all counters.
REQ-010 SHALL have port SYNC, input, 1 bit: realigns all channels.
REQ-011 SHALL have port CH_DIV, input, CH*CNT_W bits: per-channel half-period-minus-one, counted in master ticks.
REQ-012 SHALL have port CEN_BASE, output, 1 bit: master tick enable.
REQ-013 SHALL have port CLK_BASE, output, 1 bit: master square wave.
REQ-014 SHALL have port CH_CLK, output, CH bits: channel square waves.
REQ-015 SHALL have port CEN_P, output, CH bits: rising-edge enables.
REQ-016 SHALL have port CEN_N, output, CH bits: falling-edge enables.

Function
REQ-017 SHALL run master counter mcnt over 0..R_cur, where R_cur is the active ratio, then wrap to 0.
REQ-018 SHALL register CEN_BASE = (mcnt==0), so it goes high for exactly one clk every R_cur+1 clks.
REQ-019 SHALL register CLK_BASE = (mcnt >= (R_cur+1)/2), with integer division.
REQ-020 SHALL sample RATIO only at wrap (mcnt==R_cur) with RATIO_LD=1, then load R_cur and pulse RATIO_ACK in the same clk; no truncated or stretched period SHALL occur.
REQ-021 SHALL treat RATIO=0 as 1 (minimum /2).
REQ-022 SHALL keep, for each channel i, a counter ccnt[i] that advances only on CEN_BASE clks.
REQ-023 When ccnt[i]==CH_DIV[i] on a CEN_BASE clk, channel i SHALL reset ccnt[i], toggle CH_CLK[i], and pulse CEN_P[i] (0->1) or CEN_N[i] (1->0) in that same clk.
REQ-024 SHALL never assert CEN_P and CEN_N together, and SHALL never assert either outside a CEN_BASE clk.
REQ-025 SHALL sample a CH_DIV change only at ccnt reset; lowering CH_DIV below the current ccnt SHALL NOT cause an overrun.
REQ-026 While PAUSE=1: mcnt and ccnt SHALL hold, CEN_BASE/CEN_P/CEN_N/RATIO_ACK SHALL be 0, and CLK_BASE/CH_CLK SHALL hold.
REQ-027 On release of PAUSE, counting SHALL resume from the held values.
REQ-028 SYNC=1 SHALL be latched; at the next wrap, mcnt, all ccnt and all CH_CLK SHALL clear, with no CEN_N emitted, and the latch SHALL clear.
REQ-029 SYNC and ratio adoption at the same wrap SHALL both apply.
REQ-030 PAUSE SHALL take priority over the SYNC latch and over the wrap.

Reset
REQ-031 With RESET_N=0 at a clk edge: mcnt=0, ccnt=0, R_cur=DEF_RATIO, SYNC latch=0, all outputs=0.
REQ-032 The first CEN_BASE SHALL occur on the first clk after RESET_N rises, then recur every R_cur+1 clks.
REQ-033 Reset mid-period SHALL discard any pending ratio request or SYNC.

Configuration
REQ-034 With CPC_CEN_FAST_EN defined: the module SHALL add input FAST (1 bit), sampled at wrap; with FAST=1 the effective divide SHALL be max(1, ((R_cur+1)/2)-1)+1; RATIO_ACK SHALL be unaffected.
REQ-035 Without CPC_CEN_FAST_EN: the module SHALL have no FAST port and SHALL behave as FAST=0.

Structure
REQ-036 The shared package cpc_clk_pkg SHALL hold the default parameter constants and the rule for computing the effective ratio.
REQ-037 One sub-module, cpc_cen_chan, SHALL implement a single channel (ccnt, CH_CLK, CEN_P/N) and SHALL be instantiated CH times by generate.

Verification
REQ-038 Reset release with DEF_RATIO=3 and CH_DIV[0]=0 -> CEN_BASE at clks 1,5,9; CEN_P[0] at 1,9; CEN_N[0] at 5; CLK_BASE high 2 of every 4 clks.
REQ-039 RATIO=7 with RATIO_LD raised mid-period -> current /4 period completes, RATIO_ACK at wrap, then CEN_BASE every 8 clks.
REQ-040 CH_DIV[1]=2 -> CH_CLK[1] period 6 master ticks; CEN_P[1] and CEN_N[1] 3 ticks apart, never coincident.
REQ-041 PAUSE for 10 clks mid-period -> no enables; period resumes, so total interval = normal interval + 10.
REQ-042 SYNC pulse together with RATIO_LD -> at the same wrap: ratio adopted, all CH_CLK=0, no CEN_N, next CEN_P per new phase.
REQ-043 Build with CPC_CEN_FAST_EN, RATIO=3, FAST=1 -> CEN_BASE every 2 clks after the next wrap; RATIO=0 with FAST=1 -> /2.
